module_packed_logic_rx: RTL and testbench

Receive side of the 16-bit packed-word interface. The transmitter assembles words as marker[15:10], data[9:0], with bit 0 overridden by a side flag. This block accepts those words over a valid/ready handshake and checks the marker. It buffers good words in a 2-entry FIFO and presents the unpacked fields downstream; words with a bad marker are dropped and counted.

---
 rtl/module_packed_logic_rx.sv | 97 +++++++++
 tb/tb_module_packed_logic_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_packed_logic_rx.sv
// Receive side of the packed-word link: checks the marker on each accepted word,
// buffers good words in a 2-entry FIFO and unpacks the head for downstream.
module module_packed_logic_rx #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned DATA_W = 10,
  parameter logic [WORD_W-DATA_W-1:0] MARKER = 6'h3F,
  parameter int unsigned ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_flag,
  output logic [4:0]        out_sel,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  // The marker is known once a word is stored, so only the data field is buffered.
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  logic              accept, marker_ok, good, bad, pop;
  logic [DATA_W-1:0] head;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign head      = mem_q[rd_ptr_q];

  assign accept    = in_valid && in_ready;
  assign marker_ok = (in_word[WORD_W-1:DATA_W] == MARKER);
  assign good      = accept && marker_ok;
  assign bad       = accept && !marker_ok;
  assign pop       = out_valid && out_ready;

  assign out_data  = out_valid ? {head[DATA_W-1:1], 1'b0} : '0;
  assign out_flag  = out_valid & head[0];
  assign out_sel   = out_valid ? {head[4:1], head[1]} : 5'd0;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_pulse_d = bad;
    err_count_d = err_count_q;

    if (good) begin
      mem_d[wr_ptr_q] = in_word[DATA_W-1:0];
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({good, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (bad && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_module_packed_logic_rx.sv
// Bench for module_packed_logic_rx: directed scenarios plus random traffic, checked
// every cycle against a queue-based model; a second instance uses a 2-bit error counter.
module tb_module_packed_logic_rx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic        out_flag;
  logic [4:0]  out_sel;
  logic        err_pulse;
  logic [7:0]  err_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [9:0]  out_data2;
  logic        out_flag2;
  logic [4:0]  out_sel2;
  logic        err_pulse2;
  logic [1:0]  err_count2;

  int checks = 0;
  int errors = 0;

  module_packed_logic_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flag  (out_flag),
    .out_sel   (out_sel),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  module_packed_logic_rx #(.ERR_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_word   (in_word),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .out_flag  (out_flag2),
    .out_sel   (out_sel2),
    .err_pulse (err_pulse2),
    .err_count (err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue of whole words, unbounded drop count.
  logic [15:0] mq[$];
  int          mcnt;
  bit          mpulse;
  bit          m_acc, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mcnt   = 0;
      mpulse = 0;
    end else begin
      m_acc  = in_valid && (mq.size() < 2);
      m_pop  = out_ready && (mq.size() > 0);
      mpulse = 0;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        if (in_word[15:10] == 6'h3F) mq.push_back(in_word);
        else begin
          mpulse = 1;
          mcnt++;
        end
      end
    end
  end

  logic [15:0] e_head;
  logic        e_valid;
  logic [9:0]  e_data;
  logic [4:0]  e_sel;
  logic        e_flag;

  always @(negedge clk) begin
    e_valid = (mq.size() > 0);
    e_head  = e_valid ? mq[0] : 16'h0;
    e_data  = 10'((e_head % 1024) / 2 * 2);
    e_flag  = e_head[0];
    e_sel   = 5'(((e_head / 2) % 16) * 2 + ((e_head / 2) % 2));
    chk("out_valid", out_valid, e_valid);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_data", out_data, e_data);
    chk("out_flag", out_flag, e_flag);
    chk("out_sel", out_sel, e_sel);
    chk("err_pulse", err_pulse, mpulse);
    chk("err_count", err_count, (mcnt > 255) ? 255 : mcnt);
    chk("out_valid2", out_valid2, e_valid);
    chk("in_ready2", in_ready2, mq.size() < 2);
    chk("out_data2", out_data2, e_data);
    chk("out_flag2", out_flag2, e_flag);
    chk("out_sel2", out_sel2, e_sel);
    chk("err_pulse2", err_pulse2, mpulse);
    chk("err_count2", err_count2, (mcnt > 3) ? 3 : mcnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int  n;
    logic took;
    n = 0;
    took = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    while (!took && n < 50) begin
      took = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!took) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int pulses;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = 16'h0;
    out_ready = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_count", err_count, 0);
    step();
    rst = 1'b0;

    // 1: single word, one-cycle latency
    out_ready = 1'b1;
    send(16'hFE05);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 10'h204);
    chk("t1_flag", out_flag, 1);
    chk("t1_sel", out_sel, 5'b00100);
    chk("t1_err", err_count, 0);
    step();

    // 2: back-pressure with a full FIFO
    out_ready = 1'b0;
    send(16'hFC01);
    send(16'hFC02);
    chk("t2_full", in_ready, 0);
    in_valid = 1'b1;
    in_word  = 16'hFC03;
    repeat (3) step();
    chk("t2_held", in_ready, 0);
    chk("t2_head1", out_data, 10'h000);
    out_ready = 1'b1;
    step();
    chk("t2_ready_back", in_ready, 1);
    chk("t2_head2", out_data, 10'h002);
    step();
    in_valid = 1'b0;
    chk("t2_head3", out_data, 10'h002);
    chk("t2_head3_flag", out_flag, 1);
    step();
    chk("t2_empty", out_valid, 0);

    // 3: bad word among good words
    out_ready = 1'b0;
    send(16'hFC04);
    send(16'h7C12);
    chk("t3_pulse", err_pulse, 1);
    chk("t3_count", err_count, 1);
    send(16'hFC08);
    chk("t3_pulse_off", err_pulse, 0);
    chk("t3_head", out_data, 10'h004);
    out_ready = 1'b1;
    step();
    chk("t3_next", out_data, 10'h008);
    step();
    chk("t3_empty", out_valid, 0);

    // 4: saturation of the 2-bit counter
    do_reset();
    out_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_word  = 16'h0100 + 16'(i);
      step();
      pulses += int'(err_pulse2);
      chk("t4_count2", err_count2, (i + 1 > 3) ? 3 : i + 1);
    end
    in_valid = 1'b0;
    step();
    chk("t4_pulse_off", err_pulse2, 0);
    chk("t4_pulses", pulses, 5);
    chk("t4_count8", err_count, 5);

    // 5: push and pop together at ONE
    send(16'hFC10);
    in_valid  = 1'b1;
    in_word   = 16'hFC20;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5_valid", out_valid, 1);
    chk("t5_head", out_data, 10'h020);
    chk("t5_one", in_ready, 1);
    step();
    chk("t5_stable", out_data, 10'h020);

    // 6: async reset while full
    send(16'hFC31);
    chk("t6_full", in_ready, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_ready", in_ready, 1);
    chk("t6_err", err_count, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    send(16'hFC40);
    chk("t6_after_valid", out_valid, 1);
    chk("t6_after_data", out_data, 10'h040);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) in_word = {6'h3F, 10'($urandom)};
      else in_word = {6'($urandom_range(0, 62)), 10'($urandom)};
      if (c == 1500) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
